// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/redirect generation for the
// 5-stage core, with a small FSM for memory waits and redirect bubbles and
// saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 255,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             uses_rs1_d,
  input  logic             uses_rs2_d,
  input  logic [4:0]       rd_e1,
  input  logic             mem_read_e1,
  input  logic             reg_write_e1,
  input  logic             mispredict_e1,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e1,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e1,
  output logic             redirect,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BW = $clog2(REDIRECT_BUBBLES + 2);
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [BW-1:0] BUB_LOAD = BW'(REDIRECT_BUBBLES);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIR    = 2'd2
  } state_t;

  state_t        cur;
  logic [BW-1:0] bub_cnt;
  logic [WW-1:0] wait_cnt;

  logic mem_stall;
  logic load_use;
  logic do_redirect;

  assign state = cur;

  // Hazard conditions decoded from the current pipeline contents.
  always_comb begin
    mem_stall   = mem_req_m & ~mem_ready_m;
    load_use    = mem_read_e1 & reg_write_e1 & (rd_e1 != 5'd0) &
                  ((uses_rs1_d & (rs1_d == rd_e1)) |
                   (uses_rs2_d & (rs2_d == rd_e1)));
    do_redirect = mispredict_e1 & ~mem_stall & (cur != REDIR);
  end

  // Priority-encoded pipeline controls; all forced low while in reset.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e1 = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e1 = 1'b0;
    redirect = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e1 = 1'b1;
        stall_m  = 1'b1;
      end else if (do_redirect) begin
        redirect = 1'b1;
        flush_d  = 1'b1;
        flush_e1 = 1'b1;
      end else if (cur == REDIR) begin
        flush_d  = 1'b1;
      end else if (load_use && cur == RUN) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        flush_e1 = 1'b1;
      end
    end
  end

  // State machine, bubble and wait counters, sticky timeout flag.
  // MEM_WAIT exits on !mem_stall: identical to mem_ready_m while the request
  // is held, and it cannot hang if the request is withdrawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= RUN;
      bub_cnt     <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (cur)
        RUN: begin
          if (mem_stall) begin
            cur      <= MEM_WAIT;
            wait_cnt <= '0;
          end else if (do_redirect && REDIRECT_BUBBLES > 0) begin
            cur     <= REDIR;
            bub_cnt <= BUB_LOAD;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt != WAIT_MAX) begin
              wait_cnt <= wait_cnt + WW'(1);
            end
            if (wait_cnt + WW'(1) == WAIT_MAX) begin
              mem_timeout <= 1'b1;
            end
          end else if (do_redirect && REDIRECT_BUBBLES > 0) begin
            cur     <= REDIR;
            bub_cnt <= BUB_LOAD;
          end else begin
            cur <= RUN;
          end
        end
        REDIR: begin
          if (!mem_stall) begin
            if (bub_cnt <= BW'(1)) begin
              cur     <= RUN;
              bub_cnt <= '0;
            end else begin
              bub_cnt <= bub_cnt - BW'(1);
            end
          end
        end
        default: cur <= RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rd_e1;
  logic        uses_rs1_d, uses_rs2_d;
  logic        mem_read_e1, reg_write_e1, mispredict_e1;
  logic        mem_req_m, mem_ready_m;
  logic        stall_f, stall_d, stall_e1, stall_m;
  logic        flush_d, flush_e1, redirect;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // ctl bit order: stall_f stall_d stall_e1 stall_m flush_d flush_e1 redirect
  logic [6:0] ctl;
  assign ctl = {stall_f, stall_d, stall_e1, stall_m, flush_d, flush_e1, redirect};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_MEM  = 7'b1111000;
  localparam logic [6:0] C_RED  = 7'b0000111;
  localparam logic [6:0] C_BUB  = 7'b0000100;

  pipe_hazard_ctrl #(
    .REDIRECT_BUBBLES(1),
    .MEM_TIMEOUT     (4),
    .CNT_W           (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .uses_rs1_d   (uses_rs1_d),
    .uses_rs2_d   (uses_rs2_d),
    .rd_e1        (rd_e1),
    .mem_read_e1  (mem_read_e1),
    .reg_write_e1 (reg_write_e1),
    .mispredict_e1(mispredict_e1),
    .mem_req_m    (mem_req_m),
    .mem_ready_m  (mem_ready_m),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e1     (stall_e1),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e1     (flush_e1),
    .redirect     (redirect),
    .state        (state),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_d = 5'd0; rs2_d = 5'd0; rd_e1 = 5'd0;
    uses_rs1_d = 1'b0; uses_rs2_d = 1'b0;
    mem_read_e1 = 1'b0; reg_write_e1 = 1'b0; mispredict_e1 = 1'b0;
    mem_req_m = 1'b0; mem_ready_m = 1'b0;
  endtask

  // lw x5 in E, add x6,x5,x1 in D
  task automatic set_load_use();
    mem_read_e1 = 1'b1; reg_write_e1 = 1'b1; rd_e1 = 5'd5;
    rs1_d = 5'd5; uses_rs1_d = 1'b1;
    rs2_d = 5'd1; uses_rs2_d = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_ctl", 32'(ctl), 32'(C_NONE));
    check("rst_state", 32'(state), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    rst_n = 1'b1;
    step();

    // Load-use via rs1
    set_load_use(); #2;
    check("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    step();
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    check("lu_state", 32'(state), 0);
    idle_inputs(); #2;
    check("lu_gone_ctl", 32'(ctl), 32'(C_NONE));
    // rd_e1 = 0 never hazards
    set_load_use(); rd_e1 = 5'd0; rs1_d = 5'd0; #2;
    check("lu_x0_ctl", 32'(ctl), 32'(C_NONE));
    // Match via rs2
    set_load_use(); rd_e1 = 5'd7; rs2_d = 5'd7; rs1_d = 5'd3; #2;
    check("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
    step();
    check("lu_rs2_cnt", 32'(stall_cnt), 2);
    // rs2 matches but is unused
    uses_rs2_d = 1'b0; #2;
    check("lu_unused_ctl", 32'(ctl), 32'(C_NONE));
    // Not a load
    set_load_use(); mem_read_e1 = 1'b0; #2;
    check("lu_noload_ctl", 32'(ctl), 32'(C_NONE));
    idle_inputs();
    step();

    // Mispredict in RUN
    mispredict_e1 = 1'b1; #2;
    check("mp_c0_ctl", 32'(ctl), 32'(C_RED));
    step();
    mispredict_e1 = 1'b0; #2;
    check("mp_c1_state", 32'(state), 2);
    check("mp_c1_ctl", 32'(ctl), 32'(C_BUB));
    check("mp_c1_flush_cnt", 32'(flush_cnt), 1);
    step();
    check("mp_c2_state", 32'(state), 0);
    check("mp_c2_ctl", 32'(ctl), 32'(C_NONE));

    // Memory wait, 3 stall cycles
    mem_req_m = 1'b1; mem_ready_m = 1'b0; #2;
    check("mw_c0_ctl", 32'(ctl), 32'(C_MEM));
    step();
    check("mw_c1_state", 32'(state), 1);
    check("mw_c1_ctl", 32'(ctl), 32'(C_MEM));
    step();
    check("mw_c2_ctl", 32'(ctl), 32'(C_MEM));
    step();
    mem_ready_m = 1'b1; #2;
    check("mw_rdy_ctl", 32'(ctl), 32'(C_NONE));
    check("mw_rdy_state", 32'(state), 1);
    step();
    idle_inputs(); #2;
    check("mw_done_state", 32'(state), 0);
    check("mw_stall_cnt", 32'(stall_cnt), 5);
    check("mw_timeout", 32'(mem_timeout), 0);

    // Load-use coincident with mispredict: redirect wins
    set_load_use(); mispredict_e1 = 1'b1; #2;
    check("lump_ctl", 32'(ctl), 32'(C_RED));
    step();
    idle_inputs(); #2;
    check("lump_state", 32'(state), 2);
    check("lump_flush_cnt", 32'(flush_cnt), 2);
    check("lump_stall_cnt", 32'(stall_cnt), 5);
    step();
    check("lump_back_state", 32'(state), 0);
    // Mispredict held through a 2-cycle memory stall
    mispredict_e1 = 1'b1; mem_req_m = 1'b1; mem_ready_m = 1'b0; #2;
    check("mpmw_c0_ctl", 32'(ctl), 32'(C_MEM));
    step();
    check("mpmw_c1_ctl", 32'(ctl), 32'(C_MEM));
    check("mpmw_c1_state", 32'(state), 1);
    step();
    mem_ready_m = 1'b1; #2;
    check("mpmw_rdy_ctl", 32'(ctl), 32'(C_RED));
    step();
    idle_inputs(); #2;
    check("mpmw_state", 32'(state), 2);
    check("mpmw_ctl", 32'(ctl), 32'(C_BUB));
    check("mpmw_flush_cnt", 32'(flush_cnt), 3);
    step();
    check("mpmw_back_state", 32'(state), 0);

    // Timeout with MEM_TIMEOUT=4
    mem_req_m = 1'b1; mem_ready_m = 1'b0;
    step();
    check("to_state", 32'(state), 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("to_pre%0d", i), 32'(mem_timeout), 0);
    end
    step();
    check("to_set", 32'(mem_timeout), 1);
    check("to_still_stall", 32'(ctl), 32'(C_MEM));
    mem_ready_m = 1'b1;
    step();
    idle_inputs(); #2;
    check("to_sticky", 32'(mem_timeout), 1);
    check("to_run", 32'(state), 0);
    rst_n = 1'b0; #2;
    check("to_rst_clear", 32'(mem_timeout), 0);
    check("to_rst_cnt", 32'(stall_cnt), 0);
    step();
    rst_n = 1'b1;
    step();

    // Stall counter saturation
    set_load_use();
    repeat (65536 + 5) step();
    check("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_ctl", 32'(ctl), 32'(C_LU));
    idle_inputs();
    step();

    // Asynchronous reset mid-REDIRECT
    mispredict_e1 = 1'b1;
    step();
    mispredict_e1 = 1'b0; #2;
    check("ar_pre_state", 32'(state), 2);
    check("ar_pre_ctl", 32'(ctl), 32'(C_BUB));
    rst_n = 1'b0; #1;
    check("ar_ctl", 32'(ctl), 32'(C_NONE));
    check("ar_state", 32'(state), 0);
    check("ar_flush_cnt", 32'(flush_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_after_state", 32'(state), 0);
    check("ar_after_ctl", 32'(ctl), 32'(C_NONE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core: generates stall, flush and redirect controls for the fetch, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, branch/jump mispredicts detected in execute, and data-memory wait states. It tracks each multi-cycle condition in a small FSM and keeps saturating performance counters. It sits beside the decode/execute pipeline registers; `flush_e1` feeds the ID/EX register's clear, and `stall_*` feed the register enables.

## Interface
- `REDIRECT_BUBBLES`, 1: extra cycles `flush_d` stays high after a redirect, covering I-mem latency; 0 disables the REDIRECT state.
- `MEM_TIMEOUT`, 255: MEM_WAIT cycles before `mem_timeout` sets.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_d`, `rs2_d`  in  5 each  decode-stage source registers.
- `uses_rs1_d`, `uses_rs2_d`  in  1 each  decode instruction reads rs1/rs2.
- `rd_e1`  in  5  execute-stage destination.
- `mem_read_e1`, `reg_write_e1`  in  1 each  execute-stage load / writeback flags.
- `mispredict_e1`  in  1  execute resolved branch/jump contrary to prediction.
- `mem_req_m`  in  1  memory-stage access pending.
- `mem_ready_m`  in  1  data memory completes access this cycle.
- `stall_f`, `stall_d`  out  1 each  hold PC / IF/ID.
- `stall_e1`, `stall_m`  out  1 each  hold ID/EX / EX/MEM.
- `flush_d`  out  1  clear IF/ID to a NOP.
- `flush_e1`  out  1  load a bubble into ID/EX.
- `redirect`  out  1  PC mux selects the corrected target.
- `state`  out  2  RUN=0, MEM_WAIT=1, REDIRECT=2.
- `mem_timeout`  out  1  sticky; a memory wait exceeded `MEM_TIMEOUT`.
- `stall_cnt`  out  CNT_W  cycles with `stall_d`=1, saturating.
- `flush_cnt`  out  CNT_W  `redirect` pulses, saturating.

## Operation
- Conditions:
  - `mem_stall` = `mem_req_m` & !`mem_ready_m`.
  - `load_use` = `mem_read_e1` & `reg_write_e1` & `rd_e1`≠0 & ((`uses_rs1_d` & `rs1_d`==`rd_e1`) | (`uses_rs2_d` & `rs2_d`==`rd_e1`)).
  - `do_redirect` = `mispredict_e1` & !`mem_stall`, evaluated in RUN and MEM_WAIT; in REDIRECT `mispredict_e1` is ignored because E holds a bubble.
- Priority, highest first: `mem_stall` > `do_redirect` > bubble flush > `load_use`.
- `mem_stall`:
  - All four stalls = 1; `flush_d`, `flush_e1` and `redirect` = 0.
  - In REDIRECT the bubble counter holds and `flush_d` is suppressed.
- `do_redirect`:
  - `redirect`=1, `flush_d`=1, `flush_e1`=1, all stalls 0.
  - A coincident `load_use` is discarded, since it is wrong-path.
- REDIRECT, no `mem_stall`: `flush_d`=1, all other controls 0; the bubble counter decrements.
- `load_use`, RUN only: `stall_f`=`stall_d`=1, `flush_e1`=1, `stall_e1`=`stall_m`=0, for exactly one cycle per occurrence (next cycle the load has left E).
- FSM:
  - RUN → MEM_WAIT on `mem_stall`.
  - RUN → REDIRECT on `do_redirect` when `REDIRECT_BUBBLES`>0; the bubble counter loads `REDIRECT_BUBBLES`.
  - MEM_WAIT → RUN when `mem_ready_m`=1. If `mispredict_e1` is also 1 that cycle, the redirect is performed in the same cycle and the next state is REDIRECT (or RUN when `REDIRECT_BUBBLES`=0).
  - REDIRECT → RUN when the bubble counter reaches 1 and there is no `mem_stall`.
- Wait counter:
  - Clears on MEM_WAIT entry and increments each MEM_WAIT cycle.
  - When it equals `MEM_TIMEOUT`, `mem_timeout` sets and stays set until reset. The stall continues regardless.
  - Memory stalls taken in REDIRECT are not counted.
- Counters: saturate at 2^CNT_W−1 with no wrap.

## Timing
- Stall, flush and `redirect` outputs are combinational from the inputs and registered state, so they act at the same edge.
- `state`, `mem_timeout` and the counters are registered and update at the next rising edge.
- Reset (`rst_n`=0, asynchronous): `state`=RUN, `mem_timeout`=0, counters=0, internal counters=0.
- While `rst_n`=0, all stall, flush and `redirect` outputs are forced to 0.
- Reset asserted mid-MEM_WAIT or mid-REDIRECT aborts immediately; after release, operation resumes in RUN.
- Redirect latency: E-stage mispredict → `redirect`/flushes in the same cycle, then `REDIRECT_BUBBLES` cycles of `flush_d`.

## Test plan
- Load x5 in E, decode `add x6,x5,x1`:
  - `stall_f`=`stall_d`=`flush_e1`=1 for one cycle; `stall_cnt` 0→1.
  - With `rd_e1`=0: no stall.
- `mispredict_e1`=1 in RUN, `REDIRECT_BUBBLES`=1:
  - Cycle 0: `redirect`=`flush_d`=`flush_e1`=1.
  - Cycle 1: `state`=2, `flush_d`=1.
  - Cycle 2: `state`=0; `flush_cnt`=1.
- `mem_req_m`=1, `mem_ready_m`=0 for 3 cycles, then 1:
  - All stalls high for 3 cycles, `state`=1, then release; `state`=0 the cycle after ready.
- `load_use` and `mispredict_e1` in the same cycle: redirect/flush only, `stall_d`=0. Then `mispredict_e1` held through a 2-cycle `mem_stall`: redirect asserted only on the `mem_ready_m` cycle.
- `MEM_TIMEOUT`=4 with `mem_ready_m` held 0: `mem_timeout` rises after 4 MEM_WAIT cycles and stays 1 after ready; `rst_n` pulse clears it.
- Force 2^16+5 load-use stalls: `stall_cnt` holds 0xFFFF. Assert `rst_n`=0 asynchronously mid-REDIRECT: outputs 0 immediately, `state`=0.
